// File: rtl/seven_segment_display_decoder_if.sv
// Bundle between a multiplexed seven-segment driver (master) and the display decoder (slave).
interface seven_segment_display_decoder_if;
    logic [3:0] anode_bits;
    logic [6:0] seven_segments_LED_output;
    logic [3:0] decoded_ones_digit;
    logic [3:0] decoded_tens_digit;
    logic [3:0] decoded_hundreds_digit;
    logic [3:0] decoded_thousands_digit;
    logic [3:0] digit_valid;
    logic       frame_valid;
    logic       frame_done;
    logic       pattern_error;
    logic       scan_timeout;

    modport master (
        output anode_bits, seven_segments_LED_output,
        input  decoded_ones_digit, decoded_tens_digit, decoded_hundreds_digit,
               decoded_thousands_digit, digit_valid, frame_valid, frame_done,
               pattern_error, scan_timeout
    );

    modport slave (
        input  anode_bits, seven_segments_LED_output,
        output decoded_ones_digit, decoded_tens_digit, decoded_hundreds_digit,
               decoded_thousands_digit, digit_valid, frame_valid, frame_done,
               pattern_error, scan_timeout
    );
endinterface

// File: rtl/seven_segment_display_decoder.sv
// Rebuilds four hex digits from sampled anode/segment scan lines; flags bad patterns and lost scan.
// Define SEVEN_SEG_HEX_DECODE_EN to accept A-F segment codes; otherwise only 0-9 decode.
//
// state       | meaning
// ST_IDLE     | display blank, waiting for a digit enable
// ST_SETTLE   | counting identical samples of the current pattern
// ST_CAPTURED | pattern evaluated, waiting for it to change
module seven_segment_display_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                          clk_100_Mhz,
    input  logic                          reset,
    seven_segment_display_decoder_if.slave bus
);
    localparam int SCW = $clog2(STABLE_CYCLES + 1);
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SCW-1:0] STABLE_LAST  = STABLE_CYCLES[SCW-1:0];
    localparam logic [TOW-1:0] TIMEOUT_SAT  = TIMEOUT_CYCLES[TOW-1:0];
    localparam logic [TOW-1:0] TIMEOUT_LAST = TIMEOUT_SAT - 1'b1;

`ifdef SEVEN_SEG_HEX_DECODE_EN
    localparam logic HEX_DECODE_EN = 1'b1;
`else
    localparam logic HEX_DECODE_EN = 1'b0;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CAPTURED} state_t;

    state_t         r_state, w_state_nxt;
    logic [SCW-1:0] r_stable_cnt, w_cnt_nxt;
    logic [TOW-1:0] r_idle_cnt;
    logic [3:0]     r_anode_s1, r_anode_s2, r_anode_prev;
    logic [6:0]     r_seg_s1, r_seg_s2, r_seg_prev;
    logic [3:0]     r_digit [4];
    logic [3:0]     r_digit_valid, w_valid_nxt;
    logic [3:0]     r_mask, w_mask_nxt;
    logic           r_frame_valid, r_frame_done, r_pattern_error, r_scan_timeout;

    logic           w_blank, w_changed, w_eval, w_anode_ok, w_accept, w_reject, w_timeout_hit;
    logic [1:0]     w_idx;
    logic [4:0]     w_dec;

    // Returns {legal, value}; A-F legality follows the build option.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] dec;
        case (seg)
            7'h40:   dec = {1'b1, 4'h0};
            7'h79:   dec = {1'b1, 4'h1};
            7'h24:   dec = {1'b1, 4'h2};
            7'h30:   dec = {1'b1, 4'h3};
            7'h19:   dec = {1'b1, 4'h4};
            7'h12:   dec = {1'b1, 4'h5};
            7'h02:   dec = {1'b1, 4'h6};
            7'h78:   dec = {1'b1, 4'h7};
            7'h00:   dec = {1'b1, 4'h8};
            7'h10:   dec = {1'b1, 4'h9};
            7'h08:   dec = {HEX_DECODE_EN, 4'hA};
            7'h03:   dec = {HEX_DECODE_EN, 4'hB};
            7'h46:   dec = {HEX_DECODE_EN, 4'hC};
            7'h21:   dec = {HEX_DECODE_EN, 4'hD};
            7'h06:   dec = {HEX_DECODE_EN, 4'hE};
            7'h0E:   dec = {HEX_DECODE_EN, 4'hF};
            default: dec = 5'h00;
        endcase
        return dec;
    endfunction

    always_ff @(posedge clk_100_Mhz or posedge reset) begin
        if (reset) begin
            r_anode_s1   <= 4'hF;
            r_anode_s2   <= 4'hF;
            r_anode_prev <= 4'hF;
            r_seg_s1     <= 7'h7F;
            r_seg_s2     <= 7'h7F;
            r_seg_prev   <= 7'h7F;
        end else begin
            r_anode_s1   <= bus.anode_bits;
            r_anode_s2   <= r_anode_s1;
            r_anode_prev <= r_anode_s2;
            r_seg_s1     <= bus.seven_segments_LED_output;
            r_seg_s2     <= r_seg_s1;
            r_seg_prev   <= r_seg_s2;
        end
    end

    assign w_blank   = (r_anode_s2 == 4'hF);
    assign w_changed = ({r_anode_s2, r_seg_s2} != {r_anode_prev, r_seg_prev});

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_stable_cnt;
        w_eval      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_blank) begin
                    w_state_nxt = ST_SETTLE;
                    w_cnt_nxt   = SCW'(1);
                end
            end
            ST_SETTLE: begin
                if (w_blank) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_changed) begin
                    w_cnt_nxt = SCW'(1);
                end else begin
                    w_cnt_nxt = r_stable_cnt + 1'b1;
                end
            end
            ST_CAPTURED: begin
                if (w_changed) begin
                    w_state_nxt = w_blank ? ST_IDLE : ST_SETTLE;
                    w_cnt_nxt   = w_blank ? '0 : SCW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        // The sample that completes the run is evaluated on the same edge.
        if (w_state_nxt == ST_SETTLE && w_cnt_nxt == STABLE_LAST) begin
            w_state_nxt = ST_CAPTURED;
            w_eval      = 1'b1;
        end
    end

    always_comb begin
        w_anode_ok = 1'b1;
        w_idx      = 2'd0;
        case (r_anode_s2)
            4'b1110: w_idx = 2'd0;
            4'b1101: w_idx = 2'd1;
            4'b1011: w_idx = 2'd2;
            4'b0111: w_idx = 2'd3;
            default: w_anode_ok = 1'b0;
        endcase
    end

    assign w_dec         = seg_decode(r_seg_s2);
    assign w_accept      = w_eval && w_anode_ok && w_dec[4];
    assign w_reject      = w_eval && !(w_anode_ok && w_dec[4]);
    assign w_timeout_hit = !w_accept && (r_idle_cnt == TIMEOUT_LAST);

    always_comb begin
        w_mask_nxt  = (r_mask == 4'hF) ? 4'h0 : r_mask;
        w_valid_nxt = r_digit_valid;
        if (w_accept) begin
            w_mask_nxt[w_idx]  = 1'b1;
            w_valid_nxt[w_idx] = 1'b1;
        end else if (w_eval && w_anode_ok) begin
            w_valid_nxt[w_idx] = 1'b0;
        end
        if (w_timeout_hit) begin
            w_mask_nxt  = 4'h0;
            w_valid_nxt = 4'h0;
        end
    end

    always_ff @(posedge clk_100_Mhz or posedge reset) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_stable_cnt    <= '0;
            r_idle_cnt      <= '0;
            r_digit         <= '{default: 4'h0};
            r_digit_valid   <= 4'h0;
            r_mask          <= 4'h0;
            r_frame_valid   <= 1'b0;
            r_frame_done    <= 1'b0;
            r_pattern_error <= 1'b0;
            r_scan_timeout  <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_stable_cnt    <= w_cnt_nxt;
            r_digit_valid   <= w_valid_nxt;
            r_mask          <= w_mask_nxt;
            r_pattern_error <= w_reject;
            r_frame_done    <= (r_mask == 4'hF);
            if (r_mask == 4'hF)
                r_frame_valid <= 1'b1;
            else if (w_timeout_hit)
                r_frame_valid <= 1'b0;
            if (w_accept) begin
                r_digit[w_idx] <= w_dec[3:0];
                r_idle_cnt     <= '0;
                r_scan_timeout <= 1'b0;
            end else if (r_idle_cnt != TIMEOUT_SAT) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end
            if (w_timeout_hit)
                r_scan_timeout <= 1'b1;
        end
    end

    assign bus.decoded_ones_digit      = r_digit[0];
    assign bus.decoded_tens_digit      = r_digit[1];
    assign bus.decoded_hundreds_digit  = r_digit[2];
    assign bus.decoded_thousands_digit = r_digit[3];
    assign bus.digit_valid             = r_digit_valid;
    assign bus.frame_valid             = r_frame_valid;
    assign bus.frame_done              = r_frame_done;
    assign bus.pattern_error           = r_pattern_error;
    assign bus.scan_timeout            = r_scan_timeout;
endmodule

// File: tb/tb_seven_segment_display_decoder.sv
// Directed bench for the seven-segment decoder with STABLE_CYCLES=4, TIMEOUT_CYCLES=64.
module tb_seven_segment_display_decoder;
    logic clk_100_Mhz = 1'b0;
    logic reset       = 1'b1;
    int   n_checks    = 0;
    int   n_fail      = 0;
    int   fd_cnt      = 0;
    int   pe_cnt      = 0;

`ifdef SEVEN_SEG_HEX_DECODE_EN
    localparam logic [3:0] EXP_TH_HEX = 4'hA;
    localparam logic [3:0] EXP_DV_HEX = 4'h8;
    localparam int         EXP_PE_HEX = 0;
`else
    localparam logic [3:0] EXP_TH_HEX = 4'h9;
    localparam logic [3:0] EXP_DV_HEX = 4'h0;
    localparam int         EXP_PE_HEX = 1;
`endif

    seven_segment_display_decoder_if dut_if ();

    seven_segment_display_decoder #(
        .STABLE_CYCLES  (4),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk_100_Mhz (clk_100_Mhz),
        .reset       (reset),
        .bus         (dut_if)
    );

    always #5 clk_100_Mhz = ~clk_100_Mhz;

    logic [15:0] w_digits;
    logic [23:0] w_all;
    assign w_digits = {dut_if.decoded_thousands_digit, dut_if.decoded_hundreds_digit,
                       dut_if.decoded_tens_digit, dut_if.decoded_ones_digit};
    assign w_all    = {w_digits, dut_if.digit_valid, dut_if.frame_valid, dut_if.frame_done,
                       dut_if.pattern_error, dut_if.scan_timeout};

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100_Mhz);
        #1;
    endtask

    task automatic show(input logic [3:0] an, input logic [6:0] sg, input int n);
        dut_if.anode_bits                = an;
        dut_if.seven_segments_LED_output = sg;
        repeat (n) begin
            tick();
            fd_cnt += int'(dut_if.frame_done);
            pe_cnt += int'(dut_if.pattern_error);
        end
    endtask

    task automatic do_reset();
        dut_if.anode_bits                = 4'hF;
        dut_if.seven_segments_LED_output = 7'h7F;
        reset = 1'b1;
        tick();
        tick();
        check_val("reset_outputs", 32'(w_all), 32'h0);
        reset  = 1'b0;
        fd_cnt = 0;
        pe_cnt = 0;
    endtask

    task automatic scan_frame();
        show(4'b1110, 7'h24, 8);
        show(4'b1101, 7'h19, 8);
        show(4'b1011, 7'h40, 8);
        show(4'b0111, 7'h10, 8);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        dut_if.anode_bits                = 4'hF;
        dut_if.seven_segments_LED_output = 7'h7F;
        tick();

        // Test 1: latency of a single digit
        do_reset();
        show(4'b1110, 7'h30, 5);
        check_val("t1_early_valid", 32'(dut_if.digit_valid), 32'h0);
        show(4'b1110, 7'h30, 1);
        check_val("t1_valid", 32'(dut_if.digit_valid), 32'h1);
        check_val("t1_ones", 32'(dut_if.decoded_ones_digit), 32'h3);
        show(4'b1110, 7'h30, 2);
        check_val("t1_no_err", 32'(pe_cnt), 32'd0);

        // Test 2: full frame
        do_reset();
        scan_frame();
        check_val("t2_digits", 32'(w_digits), 32'h9042);
        check_val("t2_dv", 32'(dut_if.digit_valid), 32'hF);
        check_val("t2_frame_done_cnt", 32'(fd_cnt), 32'd1);
        check_val("t2_frame_valid", 32'(dut_if.frame_valid), 32'h1);

        // Test 3: unstable segments never capture
        do_reset();
        for (int i = 0; i < 4; i++) begin
            show(4'b1101, 7'h24, 3);
            show(4'b1101, 7'h30, 3);
        end
        check_val("t3_dv", 32'(dut_if.digit_valid), 32'h0);
        check_val("t3_tens", 32'(dut_if.decoded_tens_digit), 32'h0);
        check_val("t3_no_err", 32'(pe_cnt), 32'd0);

        // Test 4: illegal anode then illegal segment
        do_reset();
        show(4'b1110, 7'h30, 8);
        check_val("t4_dv_pre", 32'(dut_if.digit_valid), 32'h1);
        show(4'b1100, 7'h30, 8);
        check_val("t4_anode_err", 32'(pe_cnt), 32'd1);
        check_val("t4_dv_kept", 32'(dut_if.digit_valid), 32'h1);
        show(4'b1110, 7'h7F, 8);
        check_val("t4_seg_err", 32'(pe_cnt), 32'd2);
        check_val("t4_dv_clr", 32'(dut_if.digit_valid), 32'h0);
        check_val("t4_ones_kept", 32'(dut_if.decoded_ones_digit), 32'h3);

        // Test 5: hex code A on thousands
        do_reset();
        show(4'b0111, 7'h10, 8);
        check_val("t5_nine", 32'(dut_if.decoded_thousands_digit), 32'h9);
        show(4'b0111, 7'h08, 8);
        check_val("t5_thousands", 32'(dut_if.decoded_thousands_digit), 32'(EXP_TH_HEX));
        check_val("t5_dv", 32'(dut_if.digit_valid), 32'(EXP_DV_HEX));
        check_val("t5_err", 32'(pe_cnt), 32'(EXP_PE_HEX));

        // Test 6: timeout after a frame, recovery, reset mid-settle
        do_reset();
        scan_frame();
        check_val("t6_frame_valid", 32'(dut_if.frame_valid), 32'h1);
        waited = 0;
        while (!dut_if.scan_timeout && waited < 200) begin
            show(4'hF, 7'h7F, 1);
            waited++;
        end
        check_val("t6_timeout_delay", 32'(waited), 32'd62);
        check_val("t6_timeout", 32'(dut_if.scan_timeout), 32'h1);
        check_val("t6_fv_clr", 32'(dut_if.frame_valid), 32'h0);
        check_val("t6_dv_clr", 32'(dut_if.digit_valid), 32'h0);
        check_val("t6_digits_kept", 32'(w_digits), 32'h9042);
        show(4'b1110, 7'h79, 8);
        check_val("t6_timeout_clr", 32'(dut_if.scan_timeout), 32'h0);
        check_val("t6_ones", 32'(dut_if.decoded_ones_digit), 32'h1);
        check_val("t6_dv_one", 32'(dut_if.digit_valid), 32'h1);
        show(4'hF, 7'h7F, 4);
        show(4'b1101, 7'h12, 4);
        reset = 1'b1;
        #1;
        check_val("t6_reset_mid_settle", 32'(w_all), 32'h0);
        tick();
        reset = 1'b0;
        show(4'hF, 7'h7F, 8);
        check_val("t6_no_partial", 32'(w_all), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
